// File: rtl/i2c_bit_engine.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bit_engine
// Purpose  : I2C SCL/SDA bit engine. It generates START and STOP conditions,
//            shifts bytes out, samples the slave ACK, shifts bytes in and
//            returns the master ACK/NACK.
// Options  : `define I2C_SDA_SYNC_EN to pass i_SDA_In through a 2-flop
//            synchronizer before it is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bit_engine #(
  parameter logic [7:0] SCL_RISE       = 8'd12,
  parameter logic [7:0] SDA_SAMPLE     = 8'd25,
  parameter logic [7:0] SCL_FALL       = 8'd38,
  parameter logic [7:0] START_SDA_FALL = 8'd20,
  parameter logic [7:0] STOP_SCL_RISE  = 8'd10,
  parameter logic [7:0] STOP_SDA_RISE  = 8'd30
) (
  input  logic       i_clk10MHz,
  input  logic       i_RST_n,
  input  logic [2:0] i_Current_State,
  input  logic [7:0] i_Clock_Timer,
  input  logic       i_Timer_Flag,
  input  logic [6:0] i_Chip_Addr,
  input  logic       i_RW,
  input  logic [7:0] i_Reg_Addr,
  input  logic [7:0] i_Tx_Data,
  input  logic       i_Last_Rcv,
  input  logic       i_SDA_In,
  output logic       o_SCL,
  output logic       o_SDA_OE,
  output logic       o_Byte_Done,
  output logic       o_Ack_Error,
  output logic [7:0] o_Rx_Data,
  output logic       o_Rx_Valid
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_CHIP_ADDR = 3'd2,
    ST_REG_ADDR  = 3'd3,
    ST_DATA_SEND = 3'd4,
    ST_DATA_RCV  = 3'd5,
    ST_STOP      = 3'd6,
    ST_UNDEF     = 3'd7
  } state_t;

  state_t     cur_state;
  state_t     prev_state_q, prev_state_d;
  logic       scl_q, scl_d;
  logic       sda_oe_q, sda_oe_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_err_q, ack_err_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;

  logic       entry;
  logic       is_rcv;
  logic [7:0] load_val;
  logic [7:0] cur_shift;
  logic [3:0] cur_cnt;
  logic       sda_s;

  assign cur_state = state_t'(i_Current_State);

`ifdef I2C_SDA_SYNC_EN
  logic sda_sync1_q, sda_sync2_q;

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sda_sync1_q <= 1'b1;
      sda_sync2_q <= 1'b1;
    end else begin
      sda_sync1_q <= i_SDA_In;
      sda_sync2_q <= sda_sync1_q;
    end
  end

  assign sda_s = sda_sync2_q;
`else
  assign sda_s = i_SDA_In;
`endif

  always_comb begin
    prev_state_d = cur_state;
    scl_d        = scl_q;
    sda_oe_d     = sda_oe_q;
    byte_done_d  = 1'b0;
    ack_err_d    = ack_err_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;

    entry  = (cur_state != prev_state_q);
    is_rcv = (cur_state == ST_DATA_RCV);

    case (cur_state)
      ST_CHIP_ADDR: load_val = {i_Chip_Addr, i_RW};
      ST_REG_ADDR:  load_val = i_Reg_Addr;
      ST_DATA_SEND: load_val = i_Tx_Data;
      default:      load_val = 8'h00;
    endcase

    // On the entry cycle the freshly loaded byte drives SDA, but no sample or flag is honoured.
    cur_shift = entry ? load_val : shift_q;
    cur_cnt   = entry ? 4'd0 : bit_cnt_q;

    case (cur_state)
      ST_START: begin
        bit_cnt_d = 4'd0;
        if (entry) begin
          ack_err_d = 1'b0;
          scl_d     = 1'b1;
          sda_oe_d  = 1'b0;
        end else begin
          if (i_Clock_Timer == START_SDA_FALL) sda_oe_d = 1'b1;
          if (i_Timer_Flag)                    scl_d    = 1'b0;
        end
      end

      ST_STOP: begin
        bit_cnt_d = 4'd0;
        if (entry) begin
          scl_d    = 1'b0;
          sda_oe_d = 1'b1;
        end else begin
          if (i_Clock_Timer == STOP_SCL_RISE) scl_d    = 1'b1;
          if (i_Clock_Timer == STOP_SDA_RISE) sda_oe_d = 1'b0;
        end
      end

      ST_CHIP_ADDR, ST_REG_ADDR, ST_DATA_SEND, ST_DATA_RCV: begin
        shift_d   = cur_shift;
        bit_cnt_d = cur_cnt;

        if (i_Clock_Timer == 8'd0) begin
          if (cur_cnt == 4'd8) sda_oe_d = is_rcv ? ~i_Last_Rcv : 1'b0;
          else                 sda_oe_d = is_rcv ? 1'b0 : ~cur_shift[7];
        end

        if (i_Clock_Timer == SCL_RISE) begin
          scl_d = 1'b1;
          if (is_rcv && cur_cnt == 4'd8) begin
            rx_data_d  = cur_shift;
            rx_valid_d = 1'b1;
          end
        end

        if (i_Clock_Timer == SDA_SAMPLE && !entry) begin
          if (is_rcv && cur_cnt != 4'd8)       shift_d   = {cur_shift[6:0], sda_s};
          else if (!is_rcv && cur_cnt == 4'd8) ack_err_d = sda_s;
        end

        if (i_Clock_Timer == SCL_FALL) begin
          scl_d = 1'b0;
          if (!is_rcv && cur_cnt != 4'd8) shift_d = {cur_shift[6:0], 1'b0};
        end

        // Byte end reloads so back-to-back bytes in an unchanged state start clean.
        if (i_Timer_Flag && !entry) begin
          if (cur_cnt == 4'd8) begin
            byte_done_d = 1'b1;
            bit_cnt_d   = 4'd0;
            shift_d     = load_val;
          end else begin
            bit_cnt_d = cur_cnt + 4'd1;
          end
        end
      end

      default: begin
        scl_d     = 1'b1;
        sda_oe_d  = 1'b0;
        bit_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk10MHz or negedge i_RST_n) begin
    if (!i_RST_n) begin
      prev_state_q <= ST_IDLE;
      scl_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      byte_done_q  <= 1'b0;
      ack_err_q    <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      bit_cnt_q    <= 4'd0;
      shift_q      <= 8'h00;
    end else begin
      prev_state_q <= prev_state_d;
      scl_q        <= scl_d;
      sda_oe_q     <= sda_oe_d;
      byte_done_q  <= byte_done_d;
      ack_err_q    <= ack_err_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
    end
  end

  assign o_SCL       = scl_q;
  assign o_SDA_OE    = sda_oe_q;
  assign o_Byte_Done = byte_done_q;
  assign o_Ack_Error = ack_err_q;
  assign o_Rx_Data   = rx_data_q;
  assign o_Rx_Valid  = rx_valid_q;

endmodule
`default_nettype wire

// File: doc/i2c_bit_engine.md
Name: i2c_bit_engine

Overview:
- Sits directly downstream of the I2C clock timer.
- Consumes the master FSM state, the timer count (Clock_Timer) and the timer expiry flag.
- Produces the open-drain SCL/SDA drive for the EEPROM bus: START/STOP conditions, 8-bit byte shift-out, ACK sampling, byte shift-in and master ACK/NACK.
- Reports byte completion and receive data back to the master FSM.

Parameters:
- SCL_RISE, 8'd12: Clock_Timer value at which SCL is released high within a bit slot.
- SDA_SAMPLE, 8'd25: Clock_Timer value at which SDA is sampled (SCL high).
- SCL_FALL, 8'd38: Clock_Timer value at which SCL is driven low within a bit slot.
- START_SDA_FALL, 8'd20: Clock_Timer value in Start at which SDA is pulled low.
- STOP_SCL_RISE, 8'd10: Clock_Timer value in Stop at which SCL is released.
- STOP_SDA_RISE, 8'd30: Clock_Timer value in Stop at which SDA is released.

Ports:
- i_clk10MHz  in  1  system clock
- i_RST_n  in  1  asynchronous active-low reset
- i_Current_State  in  3  FSM state: Idle=0, Start=1, Chip_Addr_Send=2, Reg_Addr_Send=3, Data_Send=4, Data_Rcv=5, Stop=6, 7=undefined
- i_Clock_Timer  in  8  phase count from the clock timer
- i_Timer_Flag  in  1  one-cycle pulse marking the end of a bit slot / START / STOP period
- i_Chip_Addr  in  7  EEPROM device address
- i_RW  in  1  1=read, 0=write; appended as LSB of the chip address byte
- i_Reg_Addr  in  8  register address byte
- i_Tx_Data  in  8  write data byte
- i_Last_Rcv  in  1  1 = current Data_Rcv byte is last; master NACKs it
- i_SDA_In  in  1  bus SDA level
- o_SCL  out  1  SCL level (1 = released)
- o_SDA_OE  out  1  1 = drive SDA low, 0 = release
- o_Byte_Done  out  1  one-cycle pulse after 9th bit slot of a byte
- o_Ack_Error  out  1  slave NACK on last sent byte
- o_Rx_Data  out  8  last received byte
- o_Rx_Valid  out  1  one-cycle pulse with o_Rx_Data update

Behaviour:
- Reset and clock:
  - Reset is asynchronous on i_RST_n low.
  - Reset values: o_SCL=1, o_SDA_OE=0, o_Byte_Done=0, o_Ack_Error=0, o_Rx_Data=0, o_Rx_Valid=0.
  - Reset also clears the bit counter and shift register, and sets the previous-state register to Idle.
- Entry and loading:
  - Entry to a state is detected when i_Current_State differs from the registered previous state.
  - Entry to a byte state clears bit_cnt (0..8) and loads the shift register in the same cycle:
    - Chip_Addr_Send loads {i_Chip_Addr,i_RW}.
    - Reg_Addr_Send loads i_Reg_Addr.
    - Data_Send loads i_Tx_Data.
    - Data_Rcv loads 0.
  - Re-entry after Byte_Done while the state is unchanged (multi-byte Data_Send/Data_Rcv) reloads on the Byte_Done cycle.
- Idle and undefined state (7): o_SCL=1, o_SDA_OE=0; bit_cnt held at 0; o_Ack_Error holds.
- Start:
  - SCL held 1.
  - o_SDA_OE=1 from i_Clock_Timer==START_SDA_FALL.
  - o_SCL=0 on i_Timer_Flag.
  - Clears o_Ack_Error on entry.
- Byte states, per bit slot:
  - i_Clock_Timer==0: drive SDA (bit_cnt 0..7 and Data_Rcv: see below).
  - ==SCL_RISE: o_SCL=1.
  - ==SDA_SAMPLE: sample.
  - ==SCL_FALL: o_SCL=0.
  - i_Timer_Flag: bit_cnt++.
- Send states:
  - Bits 0..7: o_SDA_OE = ~shift[7], MSB first; shift left at SCL_FALL.
  - Bit 8: o_SDA_OE=0; sample at SDA_SAMPLE; o_Ack_Error set to the sampled SDA (1 = NACK).
- Data_Rcv:
  - Bits 0..7: o_SDA_OE=0; shift in i_SDA_In at SDA_SAMPLE.
  - Bit 8: o_SDA_OE = ~i_Last_Rcv.
  - o_Rx_Data/o_Rx_Valid update at bit 8 SCL_RISE.
- Byte end: i_Timer_Flag with bit_cnt==8 produces the o_Byte_Done pulse; bit_cnt wraps to 0.
- Stop:
  - Entry forces o_SCL=0, o_SDA_OE=1.
  - o_SCL=1 at STOP_SCL_RISE.
  - o_SDA_OE=0 at STOP_SDA_RISE.
- Simultaneous / mid-operation events:
  - State change takes priority over any pending sample or flag event in that cycle.
  - A state change mid-byte abandons the byte with no Byte_Done and no Rx_Valid.
  - Reset mid-byte returns the bus to released immediately, asynchronously.
- Pulse rules: o_Byte_Done and o_Rx_Valid never assert in the same cycle; each is high for exactly one clock.

Optional Feature:
- I2C_SDA_SYNC_EN defined: i_SDA_In passes through a 2-flop synchronizer (reset 1); sample points use the synchronized value, adding 2 cycles of sampling latency.
- Undefined: i_SDA_In is sampled directly.

Test Plan:
- Start, then Chip_Addr_Send with i_Chip_Addr=7'h50, i_RW=0, slave ACK (SDA=0 at bit 8) -> SDA sequence at SCL rises 1,0,1,0,0,0,0,0; o_Ack_Error=0; one o_Byte_Done after 9th flag.
- Reg_Addr_Send i_Reg_Addr=8'hA5, slave leaves SDA=1 at bit 8 -> o_Ack_Error=1 and holds through Stop; cleared on next Start.
- Data_Rcv, bus presents 8'h3C, i_Last_Rcv=1 -> o_Rx_Data=8'h3C with one-cycle o_Rx_Valid; o_SDA_OE=0 during bit 8 (NACK).
- Data_Rcv, i_Last_Rcv=0 -> o_SDA_OE=1 during bit 8 (master ACK).
- Stop -> SCL rises at timer 10 while SDA low; SDA released at timer 30; final o_SCL=1, o_SDA_OE=0.
- Reset pulsed low during bit 4 of Data_Send -> o_SCL=1 and o_SDA_OE=0 immediately; no o_Byte_Done; bit counter 0 on the next Data_Send entry.
